// File: rtl/wb_trace_checker.sv
// wb_trace_checker: captures the CPU writeback debug trace into a FIFO and
// compares each record, in order, against a golden trace stream delivered
// over a valid/ready handshake. The mismatch report and overflow flag are
// sticky until reset.
// Optional build macro: TRACE_X0_FILTER_EN -- a write to x0 is treated as
// no write (effective enable = ena && reg != 0) on both sides.
module wb_trace_checker #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             check_en,
   input  logic             debug_wb_have_inst,
   input  logic [31:0]      debug_wb_pc,
   input  logic             debug_wb_ena,
   input  logic [4:0]       debug_wb_reg,
   input  logic [31:0]      debug_wb_value,
   input  logic             gold_valid,
   output logic             gold_ready,
   input  logic [31:0]      gold_pc,
   input  logic             gold_ena,
   input  logic [4:0]       gold_reg,
   input  logic [31:0]      gold_value,
   output logic             stall_req,
   output logic [CNT_W-1:0] pass_cnt,
   output logic             err,
   output logic [3:0]       err_field,
   output logic [31:0]      err_pc,
   output logic             overflow,
   output logic             busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] STALL_TH = (AW+1)'(FIFO_DEPTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FAIL = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] value;
   } rec_t;

   rec_t             mem_q [FIFO_DEPTH];
   logic [1:0]       state_q, state_d;
   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic             err_q, err_d, overflow_q, overflow_d, stall_q, stall_d;
   logic [3:0]       err_field_q, err_field_d;
   logic [31:0]      err_pc_q, err_pc_d;

   logic             empty, full, push, pop, wr_en;
   logic             d_en, g_en, both_en;
   logic [3:0]       mask;
   rec_t             head;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign head  = mem_q[rptr_q[AW-1:0]];

   // Field-by-field compare of the FIFO head against the golden record
   always_comb begin
`ifdef TRACE_X0_FILTER_EN
      d_en = head.ena && (head.rd != 5'd0);
      g_en = gold_ena && (gold_reg != 5'd0);
`else
      d_en = head.ena;
      g_en = gold_ena;
`endif
      both_en = d_en && g_en;
      mask[0] = (head.pc != gold_pc);
      mask[1] = (d_en != g_en);
      mask[2] = both_en && (head.rd != gold_reg);
      mask[3] = both_en && (head.value != gold_value);
   end

   // Control: handshake, FIFO pointers, pass/fail bookkeeping, state
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      pass_cnt_d  = pass_cnt_q;
      err_d       = err_q;
      err_field_d = err_field_q;
      err_pc_d    = err_pc_q;
      overflow_d  = overflow_q;
      wr_en       = 1'b0;
      gold_ready  = (state_q == S_RUN) && !empty;
      pop         = gold_ready && gold_valid;
      push        = (state_q == S_RUN) && check_en && debug_wb_have_inst;
      case (state_q)
         S_IDLE: if (check_en) state_d = S_RUN;
         S_RUN: begin
            if (pop) begin
               rptr_d = rptr_q + 1'b1;
               if (mask != 4'd0) begin
                  state_d     = S_FAIL;
                  err_d       = 1'b1;
                  err_field_d = mask;
                  err_pc_d    = head.pc;
               end else begin
                  pass_cnt_d = pass_cnt_q + 1'b1;
               end
            end
            if (push) begin
               // a full FIFO can still accept when the head leaves this edge
               if (full && !pop) begin
                  state_d     = S_FAIL;
                  overflow_d  = 1'b1;
                  err_d       = 1'b1;
                  err_field_d = 4'd0;
               end else begin
                  wr_en  = 1'b1;
                  wptr_d = wptr_q + 1'b1;
               end
            end
            // drain complete: check_en low means no push can be pending
            if (state_d == S_RUN && !check_en && empty) state_d = S_IDLE;
         end
         default: ;
      endcase
      stall_d = ((wptr_d - rptr_d) >= STALL_TH);
   end

   // Control and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         pass_cnt_q  <= '0;
         err_q       <= 1'b0;
         err_field_q <= 4'd0;
         err_pc_q    <= 32'd0;
         overflow_q  <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         pass_cnt_q  <= pass_cnt_d;
         err_q       <= err_d;
         err_field_q <= err_field_d;
         err_pc_q    <= err_pc_d;
         overflow_q  <= overflow_d;
         stall_q     <= stall_d;
      end
   end

   // Record storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= '{debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value};
   end

   assign stall_req = stall_q;
   assign pass_cnt  = pass_cnt_q;
   assign err       = err_q;
   assign err_field = err_field_q;
   assign err_pc    = err_pc_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed scenarios plus randomized traffic against a
// queue-based reference model; pop results go through a scoreboard queue.
module tb_wb_trace_checker;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] value;
   } rec_t;

   typedef struct {
      logic [31:0] pass;
      logic        err;
      logic [3:0]  field;
      logic [31:0] errpc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        check_en = 1'b0, have = 1'b0, gold_valid = 1'b0;
   logic [31:0] d_pc = '0, g_pc = '0, d_val = '0, g_val = '0;
   logic        d_ena = 1'b0, g_ena = 1'b0;
   logic [4:0]  d_reg = '0, g_reg = '0;
   logic        gold_ready, stall_req, err, overflow, busy;
   logic [31:0] pass_cnt, err_pc;
   logic [3:0]  err_field;

   wb_trace_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .check_en(check_en),
      .debug_wb_have_inst(have), .debug_wb_pc(d_pc), .debug_wb_ena(d_ena),
      .debug_wb_reg(d_reg), .debug_wb_value(d_val),
      .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(g_pc),
      .gold_ena(g_ena), .gold_reg(g_reg), .gold_value(g_val),
      .stall_req(stall_req), .pass_cnt(pass_cnt), .err(err), .err_field(err_field),
      .err_pc(err_pc), .overflow(overflow), .busy(busy));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // reference model: queue of captured records and a three-way mode
   rec_t        mq[$];
   exp_t        exp_q[$];
   int          m_state = 0;   // 0 idle, 1 running, 2 failed
   logic [31:0] m_pass = '0, m_errpc = '0;
   logic        m_err = 1'b0, m_ovf = 1'b0, m_stall = 1'b0;
   logic [3:0]  m_field = '0;
   rec_t        d_rec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t rand_rec();
      rec_t r;
      r.pc    = $urandom & 32'hFFFF_FFFC;
      r.ena   = 1'($urandom);
      r.rd    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      r.value = $urandom;
      return r;
   endfunction

   // which fields disagree, taking "does this record write a register" into account
   function automatic logic [3:0] diff(input rec_t d, input rec_t g);
      bit dw, gw;
`ifdef TRACE_X0_FILTER_EN
      dw = d.ena && d.rd != 0;
      gw = g.ena && g.rd != 0;
`else
      dw = d.ena;
      gw = g.ena;
`endif
      return {dw && gw && d.value != g.value, dw && gw && d.rd != g.rd, dw != gw, d.pc != g.pc};
   endfunction

   task automatic check_state();
      chk("pass_cnt",  64'(pass_cnt),  64'(m_pass));
      chk("err",       64'(err),       64'(m_err));
      chk("err_field", 64'(err_field), 64'(m_field));
      chk("err_pc",    64'(err_pc),    64'(m_errpc));
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("stall_req", 64'(stall_req), 64'(m_stall));
      chk("busy",      64'(busy),      64'(m_state == 1));
   endtask

   // one clock: check last edge's result, drive new inputs, advance the model
   task automatic step(input bit rst, input bit ce, input bit hv, input bit gv, input int corrupt);
      rec_t g;
      bit rdy, hs, psh, was_empty;
      logic [3:0] m;
      @(posedge clk); #1;
      check_state();
      g = (mq.size() > 0) ? mq[0] : rand_rec();
      if (!g.ena && $urandom % 2 == 1) begin
         g.rd = 5'($urandom); g.value = $urandom;
      end
      case (corrupt)
         1: g.pc    = g.pc ^ 32'h4;
         2: g.ena   = ~g.ena;
         3: g.rd    = g.rd ^ 5'h1;
         4: g.value = g.value ^ 32'h1;
         default: ;
      endcase
      rst_n = !rst; check_en = ce; have = hv; gold_valid = gv;
      {d_pc, d_ena, d_reg, d_val} = d_rec;
      {g_pc, g_ena, g_reg, g_val} = g;
      #1;
      if (rst) begin
         mq.delete(); m_state = 0; m_pass = '0; m_err = 0; m_field = '0;
         m_errpc = '0; m_ovf = 0; m_stall = 0;
         return;
      end
      rdy = (m_state == 1) && mq.size() > 0;
      chk("gold_ready", 64'(gold_ready), 64'(rdy));
      hs  = rdy && gv;
      psh = (m_state == 1) && ce && hv;
      if (m_state == 0) begin
         if (ce) m_state = 1;
      end else if (m_state == 1) begin
         was_empty = (mq.size() == 0);
         if (hs) begin
            m = diff(mq.pop_front(), g);
            if (m != 0) begin
               m_state = 2; m_err = 1; m_field = m; m_errpc = g.pc ^ ((corrupt == 1) ? 32'h4 : 32'h0);
            end else m_pass++;
            exp_q.push_back('{m_pass, m_err, m_field, m_errpc});
         end
         if (psh) begin
            if (mq.size() == DEPTH) begin
               m_state = 2; m_ovf = 1; m_err = 1; m_field = '0;
            end else mq.push_back(d_rec);
         end
         if (m_state == 1 && !ce && was_empty) m_state = 0;
      end
      m_stall = (mq.size() >= DEPTH - 1);
   endtask

   // scoreboard monitor: a handshake seen before an edge is checked after it
   bit pend = 0;
   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow: pop seen with no expectation at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pass_cnt",  64'(pass_cnt),  64'(e.pass));
            chk("sb_err",       64'(err),       64'(e.err));
            chk("sb_err_field", 64'(err_field), 64'(e.field));
            chk("sb_err_pc",    64'(err_pc),    64'(e.errpc));
         end
      end
      pend = rst_n && gold_ready && gold_valid;
   end

   // three matching records; optionally corrupt the last golden value
   task automatic three(input int corrupt_last);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         d_rec = '{32'(i * 4), 1'b1, 5'd5, 32'(i + 1)};
         step(0, 1, i < 3, 1, (i == 3) ? corrupt_last : 0);
      end
      step(0, 1, 0, 1, 0);
   endtask

   initial begin
      d_rec = '0;
      step(1, 0, 0, 0, 0);
      // matching trace, then a value mismatch at pc 0x8
      three(0);
      three(4);
      // overflow: no golden traffic, push every cycle
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin d_rec = rand_rec(); step(0, 1, 1, 0, 0); end
      // write to x0 vs golden no-write
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      d_rec = '{32'h100, 1'b1, 5'd0, 32'h55};
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 2);
      step(0, 1, 0, 0, 0);
      // fill, push+pop while full, then drain with check_en low
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin d_rec = rand_rec(); step(0, 1, 1, 0, 0); end
      for (int i = 0; i < 3; i++) begin d_rec = rand_rec(); step(0, 1, 1, 1, 0); end
      for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0);
      // reset while failed with 4 records buffered, then a clean run
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin d_rec = rand_rec(); step(0, 1, 1, 0, 0); end
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin d_rec = rand_rec(); step(0, 1, 1, 1, 0); end
      // randomized episodes
      for (int e = 0; e < 8; e++) begin
         int gvp;
         gvp = (e % 4 == 0) ? 8 : 70;
         step(1, 0, 0, 0, 0);
         for (int c = 0; c < 250; c++) begin
            d_rec = rand_rec();
            step(0, ($urandom % 20) != 0, ($urandom % 100) < 75, ($urandom % 100) < gvp,
                 ($urandom % 80 == 0) ? 1 + int'($urandom % 4) : 0);
         end
      end
      step(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_state();
      @(negedge clk); #1;
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Consumer end of the single-cycle CPU's writeback debug trace (debug_wb_*).
- Captures each retired-instruction record into a small FIFO and compares it, in order, against a golden trace stream delivered over a valid/ready handshake.
- Keeps a pass count and a sticky first-error report, and raises a stall request when its FIFO is nearly full.
- Sits beside the CPU top in the simulation/FPGA test harness.

Parameters:
- FIFO_DEPTH, 8, DUT record buffer depth; power of two, minimum 4.
- CNT_W, 32, width of the pass counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- check_en  in  1  start/continue checking.
- debug_wb_have_inst  in  1  DUT record valid this cycle.
- debug_wb_pc  in  32  DUT retired PC.
- debug_wb_ena  in  1  DUT register-write enable.
- debug_wb_reg  in  5  DUT destination register.
- debug_wb_value  in  32  DUT write value.
- gold_valid  in  1  golden record available.
- gold_ready  out  1  golden record consumed this cycle.
- gold_pc  in  32  golden PC.
- gold_ena  in  1  golden write enable.
- gold_reg  in  5  golden destination register.
- gold_value  in  32  golden write value.
- stall_req  out  1  FIFO almost full; harness should freeze the CPU.
- pass_cnt  out  CNT_W  number of records matched.
- err  out  1  sticky mismatch or overflow flag.
- err_field  out  4  mismatch mask: [0] pc, [1] ena, [2] reg, [3] value.
- err_pc  out  32  DUT PC of the first failing record.
- overflow  out  1  sticky FIFO overflow.
- busy  out  1  state is RUN.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, FIFO empty, gold_ready=0, stall_req=0, pass_cnt=0, err=0, err_field=0, err_pc=0, overflow=0, busy=0. Reset mid-run discards all buffered records.
- State IDLE: no push, no pop. Go to RUN when check_en=1.
- State RUN, push: DUT record pushed when check_en=1 and debug_wb_have_inst=1.
- State RUN, pop: gold_ready = FIFO non-empty (combinational from state and count). A pop/compare occurs when gold_ready && gold_valid. The compared entry is the FIFO head.
- State RUN, drain: when check_en=0, pushes stop while pops continue; go to IDLE once the FIFO is empty with no push pending.
- State FAIL: sticky until reset. gold_ready=0, no push, no pop, counters frozen.
- Transitions to FAIL:
  - Any mismatch: registered outputs err=1, err_field=mask, err_pc=head PC, set on the edge after the handshake.
  - Push while full with no simultaneous pop: overflow=1, err=1, err_field=0. The pushed record is dropped.
- Simultaneous push and pop: legal at any occupancy, including full; count unchanged.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH. full when the MSBs differ and the rest are equal.
- Compare rules:
  - pc: always compared.
  - ena: always compared.
  - reg and value: compared only when both ena=1.
- Match: pass_cnt increments by 1 on the same edge as the pop; wraps at 2^CNT_W.
- Latency: a record pushed at edge N can be popped at edge N+1 at the earliest. err or pass_cnt is visible after edge N+1.
- stall_req: registered; 1 when count >= FIFO_DEPTH-1 after the current edge's update.
- Empty FIFO with gold_valid=1: gold_ready=0; the golden source waits.

Optional Feature:
- Macro: TRACE_X0_FILTER_EN.
- Defined: an effective enable is computed per side as ena && (reg != 0), and it replaces ena in all compare rules. Writes to x0 are then equivalent to no write, and reg/value are ignored for them.
- Undefined: raw ena/reg/value are compared exactly as stated above.

Test Plan:
- Push 3 DUT records (pc 0x0,0x4,0x8; ena=1, reg=5, value=1,2,3) with matching golden records, gold_valid=1 throughout -> pass_cnt=3, err=0, FIFO empty, busy=1.
- Golden value=0x2 vs DUT value=0x3 at pc 0x8 -> err=1, err_field=4'b1000, err_pc=0x8, pass_cnt=2, gold_ready=0 thereafter.
- gold_valid=0, DUT pushes every cycle, FIFO_DEPTH=8 -> stall_req=1 once count>=7. The 9th push without a pop -> overflow=1, err=1, err_field=0.
- DUT ena=1 reg=0 value=0x55 vs golden ena=0:
  - With TRACE_X0_FILTER_EN: pass_cnt+1, err=0.
  - Without it: err_field=4'b0010.
- Full FIFO with push and pop on the same edge -> count stays 8, no overflow. check_en dropped -> drains 8 matching records, then busy=0 (IDLE).
- rst_n=0 for one edge while in FAIL with 4 entries buffered -> all outputs return to reset values; the next check_en=1 starts a clean run.
